l0_skew_buffer: RTL and testbench

- Parametrised next-generation L0 input buffer for the corelet, sitting between the activation/weight source and the MAC array.
- `row` independent per-row FIFOs of configurable depth.
- Writes all rows in parallel through an internal registered write stage.
- Reads either all rows together (parallel mode) or as a diagonal wavefront, row i delayed i cycles (skew mode), so the systolic array is fed directly without an external skew network.

---
 rtl/l0_pkg.sv | 28 ++
 rtl/l0_row_fifo.sv | 57 +++++
 rtl/l0_skew_buffer.sv | 133 +++++++++++++
 tb/tb_l0_skew_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l0_pkg.sv
// l0_pkg: shared definitions for the L0 skew buffer.
//   l0_mode_e  : read-mode encoding (parallel / skewed), matches the rd_mode pin
//   clog2()    : ceiling log2, sizes pointers and counts
//   lane_lsb() : LSB position of a row lane inside a packed row*bw bus
package l0_pkg;

   typedef enum logic {
      L0_MODE_PAR  = 1'b0,
      L0_MODE_SKEW = 1'b1
   } l0_mode_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/l0_row_fifo.sv
// l0_row_fifo: single-row FIFO of one L0 buffer channel.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   push/wdata : write request and data (caller guarantees space, pop included)
//   pop        : pop request; ignored when the row is empty
//   head       : current head entry (valid whenever count != 0)
//   popped     : pop actually performed this cycle
//   count      : occupancy 0..depth
//   full       : count == depth
module l0_row_fifo
   import l0_pkg::*;
#(
   parameter int unsigned bw    = 4,
   parameter int unsigned depth = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [bw-1:0]           wdata,
   input  logic                    pop,
   output logic [bw-1:0]           head,
   output logic                    popped,
   output logic [clog2(depth):0]   count,
   output logic                    full
);

   localparam int unsigned AW = clog2(depth);
   localparam int unsigned CW = AW + 1;

   logic [bw-1:0] mem [depth];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   assign popped = pop && (count != '0);
   assign full   = (count == CW'(depth));
   assign head   = mem[rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)   wptr <= wptr + AW'(1);
         if (popped) rptr <= rptr + AW'(1);
         case ({push, popped})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/l0_skew_buffer.sv
// l0_skew_buffer: L0 input buffer feeding the MAC array.
//   row independent row FIFOs written in parallel through a registered write
//   stage; read either all rows at once (rd_mode=0) or as a diagonal
//   wavefront where row i pops i cycles after rd (rd_mode=1).
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   in, wr     : write data (lane i = in[bw*(i+1)-1:bw*i]) and request
//   rd, rd_mode: read request and mode sampled with it
//   out        : registered read data, same lane packing as in
//   o_valid    : per-lane valid for out
//   o_full     : any row full      o_ready : ~o_full
//   o_empty    : all rows empty
//   o_err      : only with L0_ERR_FLAG_EN; [0] sticky overflow,
//                [1] sticky underflow
// Requires row >= 2.
module l0_skew_buffer
   import l0_pkg::*;
#(
   parameter int unsigned row   = 8,
   parameter int unsigned bw    = 4,
   parameter int unsigned depth = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [row*bw-1:0]   in,
   input  logic                wr,
   input  logic                rd,
   input  logic                rd_mode,
   output logic [row*bw-1:0]   out,
   output logic [row-1:0]      o_valid,
   output logic                o_full,
   output logic                o_ready,
   output logic                o_empty
`ifdef L0_ERR_FLAG_EN
   ,
   output logic [1:0]          o_err
`endif
);

   localparam int unsigned CW = clog2(depth) + 1;

   logic                wr_q;
   logic [row*bw-1:0]   in_q;
   // rd_sr[i]/mode_sr[i]: request issued i cycles ago and its mode tag
   logic [row-1:1]      rd_sr;
   logic [row-1:1]      mode_sr;

   logic [row-1:0]      pop;
   logic [row-1:0]      popped;
   logic [row-1:0]      full_row;
   logic [bw-1:0]       head [row];
   logic [CW-1:0]       cnt  [row];
   logic                push_ok;
   logic                full_any;
   logic                empty_all;

   always_comb begin
      pop       = '0;
      full_any  = 1'b0;
      empty_all = 1'b1;
      pop[0]    = rd;
      for (int unsigned i = 1; i < row; i++) begin
         pop[i] = (rd && (rd_mode == L0_MODE_PAR)) ||
                  (rd_sr[i] && (mode_sr[i] == L0_MODE_SKEW));
      end
      for (int unsigned i = 0; i < row; i++) begin
         if (cnt[i] == CW'(depth)) full_any  = 1'b1;
         if (cnt[i] != '0)         empty_all = 1'b0;
      end
   end

   // A full row only accepts the write if it pops in the same cycle; one
   // refusing row drops the write everywhere so rows stay aligned.
   assign push_ok = wr_q && !(|(full_row & ~pop));

   for (genvar g = 0; g < row; g++) begin : g_row
      l0_row_fifo #(
         .bw    (bw),
         .depth (depth)
      ) u_fifo (
         .clk    (clk),
         .reset  (reset),
         .push   (push_ok),
         .wdata  (in_q[lane_lsb(g, bw) +: bw]),
         .pop    (pop[g]),
         .head   (head[g]),
         .popped (popped[g]),
         .count  (cnt[g]),
         .full   (full_row[g])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q    <= 1'b0;
         in_q    <= '0;
         rd_sr   <= '0;
         mode_sr <= '0;
         out     <= '0;
         o_valid <= '0;
         o_full  <= 1'b0;
         o_ready <= 1'b1;
         o_empty <= 1'b1;
      end else begin
         wr_q       <= wr;
         in_q       <= in;
         rd_sr[1]   <= rd;
         mode_sr[1] <= rd_mode;
         for (int unsigned k = 2; k < row; k++) begin
            rd_sr[k]   <= rd_sr[k-1];
            mode_sr[k] <= mode_sr[k-1];
         end
         for (int unsigned i = 0; i < row; i++) begin
            if (popped[i]) out[lane_lsb(i, bw) +: bw] <= head[i];
         end
         o_valid <= popped;
         o_full  <= full_any;
         o_ready <= !full_any;
         o_empty <= empty_all;
      end
   end

`ifdef L0_ERR_FLAG_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_err <= '0;
      end else begin
         if (wr_q && !push_ok)  o_err[0] <= 1'b1;
         if (|(pop & ~popped))  o_err[1] <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_l0_skew_buffer.sv
module tb_l0_skew_buffer;

   logic        clk;
   logic        reset;
   logic [31:0] in;
   logic        wr;
   logic        rd;
   logic        rd_mode;
   logic [31:0] out;
   logic [7:0]  o_valid;
   logic        o_full;
   logic        o_ready;
   logic        o_empty;
   logic [1:0]  o_err;

   l0_skew_buffer #(
      .row   (8),
      .bw    (4),
      .depth (64)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .wr      (wr),
      .rd      (rd),
      .rd_mode (rd_mode),
      .out     (out),
      .o_valid (o_valid),
      .o_full  (o_full),
      .o_ready (o_ready),
      .o_empty (o_empty)
`ifdef L0_ERR_FLAG_EN
      ,
      .o_err   (o_err)
`endif
   );

   typedef struct {
      logic [31:0] data;
      logic [7:0]  valid;
   } exp_t;

   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Monitor: every cycle with any valid lane consumes one expected entry.
   always @(negedge clk) begin
      if (o_valid !== 8'h00) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: got o_valid=%h out=%h, required no output", o_valid, out);
         end else begin
            exp_t e;
            logic [31:0] m;
            e = sb.pop_front();
            m = '0;
            for (int i = 0; i < 8; i++) if (e.valid[i]) m[4*i +: 4] = 4'hF;
            if (o_valid !== e.valid || (out & m) !== (e.data & m)) begin
               n_err++;
               $display("FAIL sb_out: got valid=%h out=%h, required valid=%h out=%h (lanes masked %h)",
                        o_valid, out, e.valid, e.data, m);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic expect_out(input logic [31:0] d, input logic [7:0] v);
      exp_t e;
      e.data  = d;
      e.valid = v;
      sb.push_back(e);
   endtask

   task automatic write1(input logic [31:0] d);
      wr = 1'b1;
      in = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [31:0] fdat(input int k);
      return (32'(k) * 32'h11111111) ^ 32'h0F1E2D3C;
   endfunction

   function automatic logic [31:0] gdat(input int k);
      return (32'(k) * 32'h01234567) + 32'hA5A5A5A5;
   endfunction

   initial begin
      reset   = 1'b0;
      in      = '0;
      wr      = 1'b0;
      rd      = 1'b0;
      rd_mode = 1'b0;
      o_err   = '0;

      // reset state
      idle(2);
      @(negedge clk);
      check("rst_out",     out,     32'h0);
      check("rst_valid",   o_valid, 8'h00);
      check("rst_empty",   o_empty, 1'b1);
      check("rst_ready",   o_ready, 1'b1);
      check("rst_full",    o_full,  1'b0);
`ifdef L0_ERR_FLAG_EN
      check("rst_err",     o_err,   2'b00);
`endif
      reset = 1'b1;
      idle(3);
      @(negedge clk);
      check("idle_empty",  o_empty, 1'b1);
      check("idle_valid",  o_valid, 8'h00);

      // reset mid-stream: 3 writes, skew rd, reset before its first pop edge
      tick();
      wr = 1'b1;
      in = 32'h11111111; tick();
      in = 32'h22222222; tick();
      in = 32'h33333333; tick();
      wr = 1'b0;
      idle(2);
      rd = 1'b1; rd_mode = 1'b1;
      #2 reset = 1'b0;
      rd = 1'b0; rd_mode = 1'b0;
      idle(2);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("midrst_novalid", o_valid, 8'h00);
         tick();
      end
      @(negedge clk);
      check("midrst_empty", o_empty, 1'b1);
      check("midrst_ready", o_ready, 1'b1);

      // parallel read at earliest legal cycle
      tick();
      write1(32'h76543210);
      tick();
      rd = 1'b1; rd_mode = 1'b0;
      expect_out(32'h76543210, 8'hFF);
      tick();
      rd = 1'b0;
      @(negedge clk);
      check("par_latency", o_valid, 8'hFF);
      idle(4);

      // skewed read: diagonal wavefront
      write1(32'h87654321);
      idle(3);
      rd = 1'b1; rd_mode = 1'b1;
      for (int i = 0; i < 8; i++) expect_out(32'h87654321, 8'(1 << i));
      tick();
      rd = 1'b0; rd_mode = 1'b0;
      idle(12);
      @(negedge clk);
      check("skew_empty", o_empty, 1'b1);

      // fill to 63, then 64th with precise status timing
      tick();
      wr = 1'b1;
      for (int k = 0; k < 63; k++) begin
         in = fdat(k);
         tick();
      end
      wr = 1'b0;
      idle(4);
      @(negedge clk);
      check("fill63_full",  o_full,  1'b0);
      check("fill63_empty", o_empty, 1'b0);
      tick();
      write1(fdat(63));
      tick();
      @(negedge clk);
      check("full_lag", o_full, 1'b0);
      tick();
      @(negedge clk);
      check("fill64_full",  o_full,  1'b1);
      check("fill64_ready", o_ready, 1'b0);
      // 65th write must be dropped
      tick();
      write1(32'hDEADBEEF);
      idle(4);
      @(negedge clk);
      check("drop_full", o_full, 1'b1);
`ifdef L0_ERR_FLAG_EN
      check("drop_err0", o_err, 2'b01);
`endif
      tick();
      rd = 1'b1; rd_mode = 1'b0;
      for (int k = 0; k < 64; k++) begin
         expect_out(fdat(k), 8'hFF);
         tick();
      end
      rd = 1'b0;
      idle(3);
      @(negedge clk);
      check("drain_empty", o_empty, 1'b1);
      check("drain_full",  o_full,  1'b0);

      // full with simultaneous FIFO write and parallel pop
      tick();
      wr = 1'b1;
      for (int k = 0; k < 64; k++) begin
         in = gdat(k);
         tick();
      end
      in = 32'h5A5A0FF0;
      tick();
      wr = 1'b0;
      idle(4);
      @(negedge clk);
      check("refill_full", o_full, 1'b1);
      tick();
      write1(32'hC0FFEE11);
      rd = 1'b1; rd_mode = 1'b0;
      expect_out(gdat(0), 8'hFF);
      tick();
      rd = 1'b0;
      idle(3);
      @(negedge clk);
      check("wrrd_full", o_full, 1'b1);
      tick();
      rd = 1'b1;
      for (int k = 1; k < 64; k++) begin
         expect_out(gdat(k), 8'hFF);
         tick();
      end
      expect_out(32'hC0FFEE11, 8'hFF);
      tick();
      rd = 1'b0;
      idle(3);
      @(negedge clk);
      check("wrrd_empty", o_empty, 1'b1);

      // skew pop on empty buffer
`ifdef L0_ERR_FLAG_EN
      check("pre_uflow_err", o_err, 2'b01);
`endif
      tick();
      rd = 1'b1; rd_mode = 1'b1;
      tick();
      rd = 1'b0; rd_mode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("uflow_novalid", o_valid, 8'h00);
         tick();
      end
      @(negedge clk);
      check("uflow_empty", o_empty, 1'b1);
`ifdef L0_ERR_FLAG_EN
      check("uflow_err", o_err, 2'b11);
`endif
      // pointers unchanged: a fresh word comes back intact
      tick();
      write1(32'h13579BDF);
      idle(3);
      rd = 1'b1; rd_mode = 1'b0;
      expect_out(32'h13579BDF, 8'hFF);
      tick();
      rd = 1'b0;
      idle(3);

      // wait bounded for scoreboard drain
      for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
